// File: rtl/pep_mmacc_common_param_pkg.sv
// ---------------------------------------------------------------------------
// pep_mmacc_common_param_pkg
// Shared parameters and types for the mono-mult-acc GRAM arbiter (GARB)
// clients: slot geometry, GRAM count, the request command type and a helper
// that turns slot geometry into an access-window length in cycles.
// ---------------------------------------------------------------------------
package pep_mmacc_common_param_pkg;

  localparam int GRAM_NB         = 4;
  localparam int GRAM_ID_W       = $clog2(GRAM_NB);
  localparam int GLWE_SLOT_NB    = 2;
  localparam int GARB_SLOT_CYCLE = 8;
  localparam int FEED_ADD_SLOT   = 1;
  localparam int ACC_ADD_SLOT    = 1;

  // Command issued by a client sequencer and forwarded to the arbiter.
  typedef struct packed {
    logic [GRAM_ID_W-1:0] grid;
    logic                 critical;
  } garb_cmd_t;

  localparam int GARB_CMD_W = $bits(garb_cmd_t);

  // Access-window length: the GLWE slots plus the client's extra slots.
  function automatic int garb_win_cycles(input int slot_nb, input int add_slot,
                                         input int slot_cycle);
    return (slot_nb + add_slot) * slot_cycle;
  endfunction

endpackage

// File: rtl/pep_mmacc_garb_client_if.sv
// ---------------------------------------------------------------------------
// pep_mmacc_garb_client_if
// Client <-> GRAM arbiter link.
//   garb_req / garb_req_vld / garb_req_rdy : request handshake (client drives)
//   garb_grant                             : one-cycle grant pulse (arbiter)
//   garb_avail_1h                          : arbiter availability, 1-hot GRAM
// Modports: master = client side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface pep_mmacc_garb_client_if
  import pep_mmacc_common_param_pkg::garb_cmd_t;
#(
  parameter int GRAM_NB = 4
);

  garb_cmd_t          garb_req;
  logic               garb_req_vld;
  logic               garb_req_rdy;
  logic               garb_grant;
  logic [GRAM_NB-1:0] garb_avail_1h;

  modport master (
    output garb_req, garb_req_vld,
    input  garb_req_rdy, garb_grant, garb_avail_1h
  );

  modport slave (
    input  garb_req, garb_req_vld,
    output garb_req_rdy, garb_grant, garb_avail_1h
  );

endinterface

// File: rtl/pep_mmacc_garb_window.sv
// ---------------------------------------------------------------------------
// pep_mmacc_garb_window
// Access-window generator. A grant while idle opens a WIN_CYCLES-long window
// on the next cycle. A grant while a window runs is held pending and its
// window starts the cycle after the current window's last cycle.
// Ports:
//   clk, a_rst_n             clock, asynchronous active-low reset
//   grant, grant_grid        grant pulse and the GRAM it refers to
//   win_vld/first/last/grid  registered window outputs
//   pend                     a granted window is queued behind the current one
//   gate_open                next request may be issued (idle or lead reached)
// ---------------------------------------------------------------------------
module pep_mmacc_garb_window
  import pep_mmacc_common_param_pkg::*;
#(
  parameter int WIN_CYCLES  = 24,
  parameter int LEAD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 grant,
  input  logic [GRAM_ID_W-1:0] grant_grid,
  output logic                 win_vld,
  output logic                 win_first,
  output logic                 win_last,
  output logic [GRAM_ID_W-1:0] win_grid,
  output logic                 pend,
  output logic                 gate_open
);

  localparam int CNT_W = $clog2(WIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEAD = CNT_W'(LEAD_CYCLES);

  typedef enum logic {WIN_IDLE, WIN_RUN} win_state_t;

  win_state_t           state;
  logic [CNT_W-1:0]     wcnt;
  logic [GRAM_ID_W-1:0] pend_grid;
  logic                 at_last;

  assign at_last   = (wcnt == LAST);
  assign win_vld   = (state == WIN_RUN);
  assign gate_open = (state == WIN_IDLE) || (wcnt >= LEAD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the async reset clears any queued window.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state     <= WIN_IDLE;
      wcnt      <= '0;
      win_grid  <= '0;
      win_first <= 1'b0;
      win_last  <= 1'b0;
      pend      <= 1'b0;
      pend_grid <= '0;
    end else begin
      win_first <= 1'b0;
      win_last  <= 1'b0;
      case (state)
        WIN_IDLE: begin
          if (grant) begin
            state     <= WIN_RUN;
            wcnt      <= '0;
            win_grid  <= grant_grid;
            win_first <= 1'b1;
            win_last  <= (WIN_CYCLES == 1);
          end
        end
        WIN_RUN: begin
          if (at_last) begin
            // Chain the next window with no idle cycle in between.
            if (pend || grant) begin
              wcnt      <= '0;
              win_grid  <= pend ? pend_grid : grant_grid;
              win_first <= 1'b1;
              win_last  <= (WIN_CYCLES == 1);
              pend      <= 1'b0;
            end else begin
              state <= WIN_IDLE;
              wcnt  <= '0;
            end
          end else begin
            wcnt     <= wcnt + 1'b1;
            win_last <= (wcnt == LAST - 1'b1);
            if (grant) begin
              pend      <= 1'b1;
              pend_grid <= grant_grid;
            end
          end
        end
        default: state <= WIN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pep_mmacc_garb_client.sv
// ---------------------------------------------------------------------------
// pep_mmacc_garb_client
// Requester-side GARB endpoint. Takes sequencer commands, issues them to the
// arbiter over a valid/ready handshake, waits for the grant and produces the
// cycle-accurate GRAM access window. The next request is issued during the
// tail of the current window so windows run back-to-back.
// Ports:
//   clk, a_rst_n                 clock, asynchronous active-low reset
//   cmd, cmd_vld, cmd_rdy        sequencer command handshake (cmd_rdy is comb.)
//   garb (master modport)        garb_req/_vld/_rdy, garb_grant, garb_avail_1h
//   win_vld/grid/first/last      access window
//   error                        sticky protocol error
// Build option: PEP_MMACC_GARB_CLIENT_CHECK_EN adds an availability check
// (garb_avail_1h versus the window, one cycle late) that also sets error.
// ---------------------------------------------------------------------------
module pep_mmacc_garb_client
  import pep_mmacc_common_param_pkg::garb_cmd_t;
  import pep_mmacc_common_param_pkg::GRAM_ID_W;
  import pep_mmacc_common_param_pkg::garb_win_cycles;
#(
  parameter int GLWE_SLOT_NB    = pep_mmacc_common_param_pkg::GLWE_SLOT_NB,
  parameter int GARB_SLOT_CYCLE = pep_mmacc_common_param_pkg::GARB_SLOT_CYCLE,
  parameter int ADD_SLOT        = 0,
  parameter int GRAM_NB         = pep_mmacc_common_param_pkg::GRAM_NB
) (
  input  logic                    clk,
  input  logic                    a_rst_n,
  input  garb_cmd_t               cmd,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  pep_mmacc_garb_client_if.master garb,
  output logic                    win_vld,
  output logic [GRAM_ID_W-1:0]    win_grid,
  output logic                    win_first,
  output logic                    win_last,
  output logic                    error
);

  localparam int WIN_CYCLES  = garb_win_cycles(GLWE_SLOT_NB, ADD_SLOT, GARB_SLOT_CYCLE);
  localparam int LEAD_CYCLES = (GLWE_SLOT_NB - 1) * GARB_SLOT_CYCLE;

  typedef enum logic [1:0] {REQ_IDLE, REQ_SEND, REQ_WAIT} req_state_t;

  req_state_t state;
  logic       ready_en;
  logic       gate_open;
  logic       pend;
  logic       proto_err;
  logic       avail_err;

  // ready_en keeps cmd_rdy low through reset and rises on the first edge after.
  assign cmd_rdy = ready_en && (state == REQ_IDLE) && gate_open;

  // Grant outside WAIT, grant on top of a pending window, or a grant racing
  // the acceptance of the very request it would answer.
  assign proto_err = garb.garb_grant &&
                     ((state != REQ_WAIT) || pend ||
                      ((state == REQ_SEND) && garb.garb_req_rdy));

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state             <= REQ_IDLE;
      ready_en          <= 1'b0;
      garb.garb_req     <= '0;
      garb.garb_req_vld <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        REQ_IDLE: begin
          if (cmd_vld && cmd_rdy) begin
            garb.garb_req     <= cmd;
            garb.garb_req_vld <= 1'b1;
            state             <= REQ_SEND;
          end
        end
        REQ_SEND: begin
          if (garb.garb_req_rdy) begin
            garb.garb_req_vld <= 1'b0;
            state             <= REQ_WAIT;
          end
        end
        REQ_WAIT: begin
          if (garb.garb_grant) state <= REQ_IDLE;
        end
        default: state <= REQ_IDLE;
      endcase
    end
  end

  // garb_req stays latched after the handshake, so it names the granted GRAM.
  pep_mmacc_garb_window #(
    .WIN_CYCLES  (WIN_CYCLES),
    .LEAD_CYCLES (LEAD_CYCLES)
  ) u_window (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .grant      (garb.garb_grant),
    .grant_grid (garb.garb_req.grid),
    .win_vld    (win_vld),
    .win_first  (win_first),
    .win_last   (win_last),
    .win_grid   (win_grid),
    .pend       (pend),
    .gate_open  (gate_open)
  );

`ifdef PEP_MMACC_GARB_CLIENT_CHECK_EN
  // The arbiter registers its availability, so compare against the window
  // as it was one cycle earlier.
  logic                 win_vld_d;
  logic [GRAM_ID_W-1:0] win_grid_d;
  logic [GRAM_NB-1:0]   avail_exp;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      win_vld_d  <= 1'b0;
      win_grid_d <= '0;
    end else begin
      win_vld_d  <= win_vld;
      win_grid_d <= win_grid;
    end
  end

  assign avail_exp = win_vld_d ? (GRAM_NB'(1) << win_grid_d) : '0;
  assign avail_err = (garb.garb_avail_1h != avail_exp);
`else
  logic unused_avail;
  assign unused_avail = ^garb.garb_avail_1h;
  assign avail_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) error <= 1'b0;
    else          error <= error | proto_err | avail_err;
  end

endmodule

// File: tb/tb_pep_mmacc_garb_client.sv
`timescale 1ns/1ps
module tb_pep_mmacc_garb_client;
  import pep_mmacc_common_param_pkg::*;

  localparam int SLOTS    = 2;
  localparam int SLOT_CYC = 8;
  localparam int ADD      = 1;
  localparam int W        = (SLOTS + ADD) * SLOT_CYC;   // 24
  localparam int L        = (SLOTS - 1) * SLOT_CYC;     // 8
  localparam int NG       = 4;

  logic                 clk = 1'b0;
  logic                 a_rst_n = 1'b0;
  garb_cmd_t            cmd;
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic                 win_vld, win_first, win_last, error;
  logic [GRAM_ID_W-1:0] win_grid;

  pep_mmacc_garb_client_if #(.GRAM_NB(NG)) garb ();

  pep_mmacc_garb_client #(
    .GLWE_SLOT_NB    (SLOTS),
    .GARB_SLOT_CYCLE (SLOT_CYC),
    .ADD_SLOT        (ADD),
    .GRAM_NB         (NG)
  ) dut (
    .clk       (clk),
    .a_rst_n   (a_rst_n),
    .cmd       (cmd),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .garb      (garb),
    .win_vld   (win_vld),
    .win_grid  (win_grid),
    .win_first (win_first),
    .win_last  (win_last),
    .error     (error)
  );

  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: the list of windows the arbiter has granted, each an
  // interval [start, start+W-1]; a grant in cycle n opens at max(n+1, prev+W).
  int win_start_q[$];
  int win_grid_q[$];
  int last_start = -1000;
  int req_grid   = 0;
  logic prev_vld = 1'b0;
  int prev_grid  = 0;
  logic [NG-1:0] avail_flip = '0;

  int vld_total = 0, first_total = 0, last_total = 0, run_len = 0, last_run = 0;

  task automatic tick();
    logic exp_vld, exp_first, exp_last;
    int   exp_grid;
    logic [GRAM_ID_W+2:0] exp_v, act_v;
    @(posedge clk);
    cyc++;
    #1;
    while (win_start_q.size() > 0 && cyc >= win_start_q[0] + W) begin
      void'(win_start_q.pop_front());
      void'(win_grid_q.pop_front());
    end
    exp_vld = 1'b0; exp_first = 1'b0; exp_last = 1'b0; exp_grid = 0;
    if (win_start_q.size() > 0) begin
      if (cyc >= win_start_q[0]) begin
        exp_vld   = 1'b1;
        exp_first = (cyc == win_start_q[0]);
        exp_last  = (cyc == win_start_q[0] + W - 1);
        exp_grid  = win_grid_q[0];
      end
    end
    exp_v = {exp_vld, exp_first, exp_last, GRAM_ID_W'(exp_grid)};
    act_v = {win_vld, win_first, win_last, (win_vld ? win_grid : GRAM_ID_W'(0))};
    n_checks++;
    if (act_v !== exp_v)
      $display("FAIL window cycle %0d: vld/first/last/grid got %b required %b", cyc, act_v, exp_v);
    else n_pass++;
    if (win_vld === 1'b1) begin vld_total++; run_len++; end
    else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    if (win_first === 1'b1) first_total++;
    if (win_last === 1'b1) last_total++;
    garb.garb_avail_1h = (prev_vld ? (NG'(1) << prev_grid) : NG'(0)) ^ avail_flip;
    prev_vld  = exp_vld;
    prev_grid = exp_grid;
  endtask

  task automatic assert_reset();
    a_rst_n = 1'b0;
    win_start_q.delete();
    win_grid_q.delete();
    last_start = -1000;
    req_grid   = 0;
    prev_vld   = 1'b0;
    cmd_vld = 1'b0; garb.garb_req_rdy = 1'b0; garb.garb_grant = 1'b0;
  endtask

  task automatic full_reset();
    assert_reset();
    tick(); tick();
    a_rst_n = 1'b1;
    tick();
  endtask

  task automatic send_cmd(input int g, input int c, output bit ok);
    cmd.grid = GRAM_ID_W'(g);
    cmd.critical = c[0];
    cmd_vld = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (cmd_rdy === 1'b1) ok = 1'b1;
      tick();
    end
    cmd_vld = 1'b0;
    if (ok) req_grid = g;
    else begin
      n_checks++;
      $display("FAIL cmd_accept: cmd_rdy never rose within 300 cycles, got 0 required 1");
    end
  endtask

  task automatic accept_req();
    garb.garb_req_rdy = 1'b1;
    tick();
    garb.garb_req_rdy = 1'b0;
  endtask

  task automatic give_grant();
    int s;
    s = (cyc + 1 > last_start + W) ? cyc + 1 : last_start + W;
    win_start_q.push_back(s);
    win_grid_q.push_back(req_grid);
    last_start = s;
    garb.garb_grant = 1'b1;
    tick();
    garb.garb_grant = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && cyc < last_start + W + 1; i++) tick();
  endtask

  task automatic test_reset();
    garb_cmd_t zero_req;
    zero_req = '0;
    assert_reset();
    tick(); tick();
    n_checks++; if (cmd_rdy !== 1'b0) $display("FAIL rst_cmd_rdy: got %b required 0", cmd_rdy); else n_pass++;
    n_checks++; if (garb.garb_req_vld !== 1'b0) $display("FAIL rst_req_vld: got %b required 0", garb.garb_req_vld); else n_pass++;
    n_checks++; if (garb.garb_req !== zero_req) $display("FAIL rst_req: got %h required 0", garb.garb_req); else n_pass++;
    n_checks++; if ({win_vld, win_first, win_last, win_grid} !== '0) $display("FAIL rst_window: got %b required 0", {win_vld, win_first, win_last, win_grid}); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL rst_error: got %b required 0", error); else n_pass++;
    a_rst_n = 1'b1;
    #1;
    n_checks++; if (cmd_rdy !== 1'b0) $display("FAIL rst_release_rdy: got %b required 0", cmd_rdy); else n_pass++;
    tick();
    n_checks++; if (cmd_rdy !== 1'b1) $display("FAIL rst_after_rdy: got %b required 1", cmd_rdy); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    int v0, f0, l0;
    garb_cmd_t exp_req;
    v0 = vld_total; f0 = first_total; l0 = last_total;
    send_cmd(3, 1, ok);
    exp_req.grid = 2'd3; exp_req.critical = 1'b1;
    n_checks++; if (garb.garb_req_vld !== 1'b1 || garb.garb_req !== exp_req)
      $display("FAIL single_req: got vld=%b req=%h required vld=1 req=%h", garb.garb_req_vld, garb.garb_req, exp_req); else n_pass++;
    accept_req();
    n_checks++; if (garb.garb_req_vld !== 1'b0) $display("FAIL single_req_drop: got %b required 0", garb.garb_req_vld); else n_pass++;
    repeat (4) tick();
    give_grant();
    n_checks++; if (win_first !== 1'b1 || win_grid !== 2'd3)
      $display("FAIL single_first: got first=%b grid=%0d required first=1 grid=3", win_first, win_grid); else n_pass++;
    drain();
    n_checks++; if (vld_total - v0 != W || last_run != W)
      $display("FAIL single_len: got %0d cycles run %0d required %0d", vld_total - v0, last_run, W); else n_pass++;
    n_checks++; if (first_total - f0 != 1 || last_total - l0 != 1)
      $display("FAIL single_pulses: got first=%0d last=%0d required 1/1", first_total - f0, last_total - l0); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL single_error: got %b required 0", error); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok, got;
    int s, v0, f0;
    logic exp_rdy;
    v0 = vld_total; f0 = first_total;
    send_cmd(1, 0, ok);
    accept_req();
    give_grant();
    s = last_start;
    cmd.grid = 2'd2; cmd.critical = 1'b0; cmd_vld = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_rdy = (cyc - s >= L);
      n_checks++;
      if (cmd_rdy !== exp_rdy) $display("FAIL gate wcnt=%0d: cmd_rdy got %b required %b", cyc - s, cmd_rdy, exp_rdy);
      else n_pass++;
      if (cmd_rdy === 1'b1) begin tick(); got = 1'b1; break; end
      tick();
    end
    cmd_vld = 1'b0;
    req_grid = 2;
    n_checks++; if (!got) $display("FAIL gate_timeout: cmd_rdy got 0 required 1 by wcnt=%0d", L); else n_pass++;
    accept_req();
    for (int i = 0; i < 40 && cyc - s < 20; i++) tick();
    give_grant();
    drain();
    n_checks++; if (vld_total - v0 != 2 * W || last_run != 2 * W)
      $display("FAIL b2b_len: got total %0d run %0d required %0d", vld_total - v0, last_run, 2 * W); else n_pass++;
    n_checks++; if (first_total - f0 != 2) $display("FAIL b2b_first: got %0d required 2", first_total - f0); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL b2b_error: got %b required 0", error); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int v0;
    garb_cmd_t exp_req;
    v0 = vld_total;
    send_cmd(2, 1, ok);
    exp_req.grid = 2'd2; exp_req.critical = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (garb.garb_req_vld !== 1'b1 || garb.garb_req !== exp_req)
        $display("FAIL bp_hold %0d: got vld=%b req=%h required vld=1 req=%h", i, garb.garb_req_vld, garb.garb_req, exp_req);
      else n_pass++;
      tick();
    end
    n_checks++; if (vld_total != v0) $display("FAIL bp_no_window: got %0d window cycles required 0", vld_total - v0); else n_pass++;
    accept_req();
    give_grant();
    drain();
    n_checks++; if (error !== 1'b0) $display("FAIL bp_error: got %b required 0", error); else n_pass++;
  endtask

  task automatic test_spurious_grant();
    give_grant();
    n_checks++; if (error !== 1'b1) $display("FAIL spurious_set: got %b required 1", error); else n_pass++;
    repeat (5) tick();
    n_checks++; if (error !== 1'b1) $display("FAIL spurious_sticky: got %b required 1", error); else n_pass++;
    drain();
    full_reset();
    n_checks++; if (error !== 1'b0) $display("FAIL spurious_clear: got %b required 0", error); else n_pass++;
`ifdef PEP_MMACC_GARB_CLIENT_CHECK_EN
    begin
      bit ok;
      send_cmd(1, 0, ok);
      accept_req();
      give_grant();
      repeat (3) tick();
      n_checks++; if (error !== 1'b0) $display("FAIL avail_ok: got %b required 0", error); else n_pass++;
      avail_flip = 4'b1000;
      tick();
      avail_flip = '0;
      tick();
      n_checks++; if (error !== 1'b1) $display("FAIL avail_bad: got %b required 1", error); else n_pass++;
      drain();
      full_reset();
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s;
    send_cmd(0, 0, ok);
    accept_req();
    give_grant();
    s = last_start;
    send_cmd(2, 1, ok);
    accept_req();
    for (int i = 0; i < 30 && cyc - s < 10; i++) tick();
    give_grant();
    for (int i = 0; i < 30 && cyc - s < 12; i++) tick();
    n_checks++; if (win_vld !== 1'b1) $display("FAIL mid_pre: win_vld got %b required 1", win_vld); else n_pass++;
    assert_reset();
    #1;
    n_checks++; if (win_vld !== 1'b0 || garb.garb_req_vld !== 1'b0 || cmd_rdy !== 1'b0)
      $display("FAIL mid_clear: vld/req_vld/rdy got %b%b%b required 000", win_vld, garb.garb_req_vld, cmd_rdy); else n_pass++;
    tick(); tick();
    a_rst_n = 1'b1;
    repeat (30) tick();
    n_checks++; if (error !== 1'b0) $display("FAIL mid_error: got %b required 0", error); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int f0, l0, g;
    f0 = first_total; l0 = last_total;
    for (int i = 0; i < 1000; i++) begin
      g = $urandom_range(0, NG - 1);
      send_cmd(g, $urandom_range(0, 1), ok);
      if (!ok) break;
      repeat ($urandom_range(0, 3)) tick();
      accept_req();
      repeat ($urandom_range(0, 6)) tick();
      for (int k = 0; k < 100 && last_start > cyc; k++) tick();
      give_grant();
    end
    drain();
    n_checks++; if (first_total - f0 != 1000 || last_total - l0 != 1000)
      $display("FAIL random_windows: got first=%0d last=%0d required 1000", first_total - f0, last_total - l0); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL random_error: got %b required 0", error); else n_pass++;
  endtask

  initial begin
    cmd = '0;
    cmd_vld = 1'b0;
    garb.garb_req_rdy = 1'b0;
    garb.garb_grant = 1'b0;
    garb.garb_avail_1h = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_spurious_grant();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
